// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data bus between the MEM-stage load/store unit and memory
interface mem_stage_lsu_if;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;

   modport master (
      output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
      input  dbus_ack, dbus_rdata
   );

   modport slave (
      input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
      output dbus_ack, dbus_rdata
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I memory-access stage: bus loads/stores, alignment, timeout, WB select
module mem_stage_lsu #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        have_inst_in,
   input  logic [31:0] pc_in,
   input  logic [4:0]  wR_in,
   input  logic [31:0] alu_c_in,
   input  logic [31:0] rD2_in,
   input  logic [31:0] imm_in,
   input  logic        rf_we_in,
   input  logic [1:0]  wd_sel_in,
   input  logic        mem_re_in,
   input  logic        mem_we_in,
   input  logic [2:0]  funct3_in,
   mem_stage_lsu_if.master dbus,
   output logic [4:0]  wR_out,
   output logic [31:0] wD_out,
   output logic [31:0] pc_out,
   output logic        have_inst_out,
   output logic        rf_we_out,
   output logic        stall_req,
   output logic        misalign,
   output logic        bus_timeout
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rdata_q;
   logic             to_q;

   logic        mem_op, mis, access, mis_op;
   logic [3:0]  be_next;
   logic [31:0] wdata_next, wd_normal, load_data, lane;

   assign mem_op = have_inst_in & (mem_re_in | mem_we_in);
   // funct3[1:0]: 00 byte, 01 half, 1x word
   assign mis    = ((funct3_in[1:0] == 2'b01) & alu_c_in[0]) |
                   (funct3_in[1] & (alu_c_in[1:0] != 2'b00));
   assign access = mem_op & ~mis;
   assign mis_op = mem_op & mis;

   always_comb begin
      be_next    = 4'b1111;
      wdata_next = rD2_in;
      case (funct3_in[1:0])
         2'b00: begin
            be_next    = 4'b0001 << alu_c_in[1:0];
            wdata_next = {4{rD2_in[7:0]}};
         end
         2'b01: begin
            be_next    = alu_c_in[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{rD2_in[15:0]}};
         end
         default: ;
      endcase
   end

   assign lane = rdata_q >> {alu_c_in[1:0], 3'b000};

   always_comb begin
      load_data = rdata_q;
      case (funct3_in)
         3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_data = {24'd0, lane[7:0]};
         3'b101:  load_data = {16'd0, lane[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      wd_normal = alu_c_in;
      case (wd_sel_in)
         2'b10:   wd_normal = pc_in + 32'd4;
         2'b11:   wd_normal = imm_in;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         dbus.dbus_req   <= 1'b0;
         dbus.dbus_we    <= 1'b0;
         dbus.dbus_addr  <= 32'd0;
         dbus.dbus_be    <= 4'd0;
         dbus.dbus_wdata <= 32'd0;
         cnt             <= '0;
         rdata_q         <= 32'd0;
         to_q            <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  state           <= REQ;
                  dbus.dbus_req   <= 1'b1;
                  dbus.dbus_we    <= mem_we_in;
                  dbus.dbus_addr  <= {alu_c_in[31:2], 2'b00};
                  dbus.dbus_be    <= be_next;
                  dbus.dbus_wdata <= wdata_next;
                  cnt             <= '0;
               end
            end
            REQ: begin
               if (dbus.dbus_ack) begin
                  dbus.dbus_req <= 1'b0;
                  if (!dbus.dbus_we) rdata_q <= dbus.dbus_rdata;
                  state <= DONE;
               end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  dbus.dbus_req <= 1'b0;
                  to_q          <= 1'b1;
                  state         <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               to_q  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // EX/MEM is frozen by stall_req, so the held inputs still describe the access in DONE
   always_comb begin
      wR_out        = wR_in;
      pc_out        = pc_in;
      have_inst_out = 1'b0;
      rf_we_out     = 1'b0;
      stall_req     = 1'b0;
      misalign      = 1'b0;
      bus_timeout   = 1'b0;
      wD_out        = 32'd0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (access) begin
                  stall_req = 1'b1;
               end else if (mis_op) begin
                  misalign      = 1'b1;
                  have_inst_out = have_inst_in;
               end else begin
                  have_inst_out = have_inst_in;
                  rf_we_out     = rf_we_in;
                  wD_out        = wd_normal;
               end
            end
            REQ: stall_req = 1'b1;
            DONE: begin
               have_inst_out = have_inst_in;
               rf_we_out     = rf_we_in & ~to_q;
               bus_timeout   = to_q;
               if (!to_q) wD_out = (wd_sel_in == 2'b01) ? load_data : wd_normal;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
   localparam int TMO = 16;

   logic        clk, rst;
   logic        have_inst_in, rf_we_in, mem_re_in, mem_we_in;
   logic [31:0] pc_in, alu_c_in, rD2_in, imm_in;
   logic [4:0]  wR_in;
   logic [1:0]  wd_sel_in;
   logic [2:0]  funct3_in;
   logic [4:0]  wR_out;
   logic [31:0] wD_out, pc_out;
   logic        have_inst_out, rf_we_out, stall_req, misalign, bus_timeout;
   int          total, bad;

   mem_stage_lsu_if bus ();

   mem_stage_lsu #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .have_inst_in(have_inst_in), .pc_in(pc_in), .wR_in(wR_in), .alu_c_in(alu_c_in),
      .rD2_in(rD2_in), .imm_in(imm_in), .rf_we_in(rf_we_in), .wd_sel_in(wd_sel_in),
      .mem_re_in(mem_re_in), .mem_we_in(mem_we_in), .funct3_in(funct3_in),
      .dbus(bus),
      .wR_out(wR_out), .wD_out(wD_out), .pc_out(pc_out), .have_inst_out(have_inst_out),
      .rf_we_out(rf_we_out), .stall_req(stall_req), .misalign(misalign), .bus_timeout(bus_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inst();
      have_inst_in = 1'b0; mem_re_in = 1'b0; mem_we_in = 1'b0; rf_we_in = 1'b0;
      wd_sel_in = 2'b00;
   endtask

   // One memory instruction from IDLE through DONE; ack_after = REQ cycles without ack before the ack
   task automatic run_mem_op(input logic is_store, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] rdata, input int ack_after);
      int          nbytes, ofs, req_cycles, req_seen;
      logic        timed_out;
      logic [31:0] exp_addr, exp_wdata, exp_load, mask, exp_wd;
      logic [3:0]  exp_be;
      nbytes    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      ofs       = int'(addr % 4);
      exp_addr  = addr - (addr % 4);
      exp_be    = (nbytes == 4) ? 4'hF : 4'(((1 << nbytes) - 1) << ofs);
      exp_wdata = (nbytes == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                  (nbytes == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
      exp_load  = rdata >> (8 * ofs);
      if (nbytes < 4) begin
         mask     = (32'd1 << (8 * nbytes)) - 32'd1;
         exp_load = exp_load & mask;
         if (!f3[2] && exp_load > (mask >> 1)) exp_load = exp_load - mask - 32'd1;
      end
      timed_out  = (ack_after >= TMO);
      req_cycles = timed_out ? TMO : ack_after + 1;
      exp_wd     = timed_out ? 32'd0 : (is_store ? addr : exp_load);

      have_inst_in = 1'b1; mem_re_in = ~is_store; mem_we_in = is_store; funct3_in = f3;
      alu_c_in = addr; rD2_in = sdata; rf_we_in = ~is_store; wd_sel_in = is_store ? 2'b00 : 2'b01;
      pc_in = $urandom; wR_in = 5'($urandom); imm_in = $urandom;

      @(negedge clk);
      total++; if (stall_req !== 1'b1 || have_inst_out !== 1'b0 || rf_we_out !== 1'b0) begin
         bad++; $display("FAIL idle_detect stall=%b have=%b we=%b want 1 0 0", stall_req, have_inst_out, rf_we_out); end
      total++; if (bus.dbus_req !== 1'b0) begin
         bad++; $display("FAIL req_early got=%b want 0", bus.dbus_req); end
      step();

      req_seen = 0;
      for (int k = 0; k < req_cycles; k++) begin
         @(negedge clk);
         if (bus.dbus_req === 1'b1) req_seen++;
         total++; if (stall_req !== 1'b1 || have_inst_out !== 1'b0 || rf_we_out !== 1'b0) begin
            bad++; $display("FAIL req_bubble cyc=%0d stall=%b have=%b we=%b want 1 0 0", k, stall_req, have_inst_out, rf_we_out); end
         total++; if (bus.dbus_addr !== exp_addr || bus.dbus_be !== exp_be || bus.dbus_we !== is_store) begin
            bad++; $display("FAIL req_bus addr=%h be=%b we=%b want %h %b %b", bus.dbus_addr, bus.dbus_be, bus.dbus_we, exp_addr, exp_be, is_store); end
         if (is_store) begin
            total++; if (bus.dbus_wdata !== exp_wdata) begin
               bad++; $display("FAIL req_wdata got=%h want %h", bus.dbus_wdata, exp_wdata); end
         end
         bus.dbus_ack   = (k == ack_after);
         bus.dbus_rdata = (k == ack_after) ? rdata : $urandom;
         step();
         bus.dbus_ack = 1'b0;
      end
      total++; if (req_seen != req_cycles) begin
         bad++; $display("FAIL req_cycles got=%0d want %0d", req_seen, req_cycles); end

      @(negedge clk);
      total++; if (stall_req !== 1'b0 || have_inst_out !== 1'b1 || bus.dbus_req !== 1'b0) begin
         bad++; $display("FAIL done_ctl stall=%b have=%b req=%b want 0 1 0", stall_req, have_inst_out, bus.dbus_req); end
      total++; if (rf_we_out !== (~is_store & ~timed_out) || bus_timeout !== timed_out) begin
         bad++; $display("FAIL done_we rf_we=%b to=%b want %b %b", rf_we_out, bus_timeout, ~is_store & ~timed_out, timed_out); end
      total++; if (wD_out !== exp_wd || pc_out !== pc_in || wR_out !== wR_in) begin
         bad++; $display("FAIL done_wd got=%h want %h", wD_out, exp_wd); end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; have_inst_in = 1'b1; mem_re_in = 1'b1; mem_we_in = 1'b0; rf_we_in = 1'b1;
      funct3_in = 3'b010; alu_c_in = 32'h105; wd_sel_in = 2'b00;
      step(); step();
      @(negedge clk);
      total++; if (have_inst_out !== 1'b0 || rf_we_out !== 1'b0 || stall_req !== 1'b0 ||
                   misalign !== 1'b0 || bus_timeout !== 1'b0 || wD_out !== 32'd0) begin
         bad++; $display("FAIL reset_out have=%b we=%b stall=%b mis=%b to=%b wd=%h want all 0",
                         have_inst_out, rf_we_out, stall_req, misalign, bus_timeout, wD_out); end
      alu_c_in = 32'h104;
      step();
      @(negedge clk);
      total++; if (bus.dbus_req !== 1'b0 || stall_req !== 1'b0) begin
         bad++; $display("FAIL reset_bus req=%b stall=%b want 0 0", bus.dbus_req, stall_req); end
      step();
      clear_inst();
      rst = 1'b0;
      step();
   endtask

   task automatic test_alu();
      logic [31:0] exp;
      for (int i = 0; i < 8; i++) begin
         have_inst_in = 1'b1; mem_re_in = 1'b0; mem_we_in = 1'b0;
         alu_c_in = (i == 0) ? 32'h1234 : $urandom; imm_in = $urandom; pc_in = $urandom;
         wR_in = (i == 0) ? 5'd5 : 5'($urandom); rf_we_in = (i == 0) ? 1'b1 : 1'($urandom);
         wd_sel_in = (i == 0) ? 2'b00 : (i % 3 == 1) ? 2'b10 : (i % 3 == 2) ? 2'b11 : 2'b00;
         exp = (wd_sel_in == 2'b10) ? pc_in + 4 : (wd_sel_in == 2'b11) ? imm_in : alu_c_in;
         #1;
         total++; if (wD_out !== exp || rf_we_out !== rf_we_in || have_inst_out !== 1'b1 ||
                      wR_out !== wR_in || pc_out !== pc_in) begin
            bad++; $display("FAIL alu_pass i=%0d wd=%h we=%b want %h %b", i, wD_out, rf_we_out, exp, rf_we_in); end
         @(negedge clk);
         total++; if (stall_req !== 1'b0 || bus.dbus_req !== 1'b0) begin
            bad++; $display("FAIL alu_nobus stall=%b req=%b want 0 0", stall_req, bus.dbus_req); end
         step();
      end
      clear_inst();
   endtask

   task automatic test_directed();
      run_mem_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
      run_mem_op(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 3);
      clear_inst(); step();
   endtask

   task automatic test_misalign();
      logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b101};
      for (int i = 0; i < 6; i++) begin
         have_inst_in = 1'b1; rf_we_in = 1'b1; wd_sel_in = 2'b01;
         mem_re_in = (i % 2 == 0); mem_we_in = (i % 2 == 1);
         funct3_in = (i == 0) ? 3'b010 : f3s[i % 3];
         alu_c_in = (i == 0) ? 32'h105 : (($urandom & 32'hFFFF_FFFC) | ((funct3_in == 3'b010) ? 32'd2 : 32'd1));
         @(negedge clk);
         total++; if (misalign !== 1'b1 || stall_req !== 1'b0 || rf_we_out !== 1'b0 ||
                      have_inst_out !== 1'b1 || wD_out !== 32'd0) begin
            bad++; $display("FAIL misalign i=%0d mis=%b stall=%b we=%b have=%b wd=%h want 1 0 0 1 0",
                            i, misalign, stall_req, rf_we_out, have_inst_out, wD_out); end
         step();
         @(negedge clk);
         total++; if (bus.dbus_req !== 1'b0) begin
            bad++; $display("FAIL misalign_req got=%b want 0", bus.dbus_req); end
         step();
      end
      clear_inst(); step();
   endtask

   task automatic test_random_ops();
      logic [2:0] ld [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0] sd [3] = '{3'b000, 3'b001, 3'b010};
      for (int i = 0; i < 16; i++) begin
         logic        st;
         logic [2:0]  f3;
         logic [31:0] a;
         st = 1'($urandom);
         f3 = st ? sd[$urandom_range(0, 2)] : ld[$urandom_range(0, 4)];
         a  = $urandom;
         if (f3[1]) a = a & 32'hFFFF_FFFC;
         else if (f3[0]) a = a & 32'hFFFF_FFFE;
         run_mem_op(st, f3, a, $urandom, $urandom, $urandom_range(0, 4));
         if (i % 4 == 3) begin clear_inst(); step(); end
      end
      clear_inst(); step();
   endtask

   task automatic test_timeout();
      run_mem_op(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0, TMO);
      run_mem_op(1'b0, 3'b010, 32'h0000_0800, 32'h0, 32'h1357_9BDF, TMO - 1);
      clear_inst();
      @(negedge clk);
      total++; if (bus_timeout !== 1'b0 || stall_req !== 1'b0) begin
         bad++; $display("FAIL timeout_clear to=%b stall=%b want 0 0", bus_timeout, stall_req); end
      step();
   endtask

   task automatic test_reset_in_req();
      have_inst_in = 1'b1; mem_re_in = 1'b1; mem_we_in = 1'b0; rf_we_in = 1'b1;
      wd_sel_in = 2'b01; funct3_in = 3'b010; alu_c_in = 32'h0000_0C00;
      step(); step(); step();
      rst = 1'b1;
      @(negedge clk);
      total++; if (stall_req !== 1'b0 || have_inst_out !== 1'b0 || rf_we_out !== 1'b0 || wD_out !== 32'd0) begin
         bad++; $display("FAIL rst_req_out stall=%b have=%b we=%b wd=%h want 0 0 0 0", stall_req, have_inst_out, rf_we_out, wD_out); end
      step();
      rst = 1'b0; clear_inst();
      @(negedge clk);
      total++; if (bus.dbus_req !== 1'b0 || stall_req !== 1'b0) begin
         bad++; $display("FAIL rst_req_drop req=%b stall=%b want 0 0", bus.dbus_req, stall_req); end
      bus.dbus_ack = 1'b1; bus.dbus_rdata = $urandom;
      step();
      bus.dbus_ack = 1'b0;
      have_inst_in = 1'b1; rf_we_in = 1'b1; wd_sel_in = 2'b00; alu_c_in = 32'hCAFE_0001; wR_in = 5'd9;
      @(negedge clk);
      total++; if (stall_req !== 1'b0 || rf_we_out !== 1'b1 || wD_out !== 32'hCAFE_0001 ||
                   bus_timeout !== 1'b0 || bus.dbus_req !== 1'b0) begin
         bad++; $display("FAIL rst_late_ack stall=%b we=%b wd=%h to=%b req=%b want 0 1 cafe0001 0 0",
                         stall_req, rf_we_out, wD_out, bus_timeout, bus.dbus_req); end
      step();
      clear_inst(); step();
   endtask

   task automatic test_back_to_back();
      run_mem_op(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h0, 0);
      run_mem_op(1'b0, 3'b100, 32'h0000_0012, 32'h0, 32'h00A5_0000, 0);
      run_mem_op(1'b0, 3'b101, 32'h0000_0016, 32'h0, 32'hF00D_1234, 1);
      run_mem_op(1'b1, 3'b010, 32'h0000_0018, 32'h1234_5678, 32'h0, 2);
      clear_inst(); step();
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; clear_inst();
      pc_in = 32'd0; wR_in = 5'd0; alu_c_in = 32'd0; rD2_in = 32'd0; imm_in = 32'd0; funct3_in = 3'b000;
      bus.dbus_ack = 1'b0; bus.dbus_rdata = 32'd0;
      test_reset();
      test_alu();
      test_directed();
      test_misalign();
      test_random_ops();
      test_timeout();
      test_reset_in_req();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
